// File: rtl/alu_issuer_pkg.sv
// Shared definitions for the ALU instruction issuer: supported opcodes,
// instruction field positions, legality check and word encoders.
package alu_issuer_pkg;

    // Opcodes the ALU implements
    localparam logic [5:0] OP_00 = 6'h00;
    localparam logic [5:0] OP_01 = 6'h01;
    localparam logic [5:0] OP_02 = 6'h02;
    localparam logic [5:0] OP_03 = 6'h03;
    localparam logic [5:0] OP_04 = 6'h04;
    localparam logic [5:0] OP_05 = 6'h05;
    localparam logic [5:0] OP_06 = 6'h06;
    localparam logic [5:0] OP_0A = 6'h0A;
    localparam logic [5:0] OP_0B = 6'h0B;

    // Least-significant bit of each field inside the 32-bit word
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_LSB   = 0;

    // Buffered entry: {is_itype, word}
    localparam int unsigned ENTRY_W = 33;

    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal;
        case (op)
            OP_00, OP_01, OP_02, OP_03, OP_04, OP_05, OP_06, OP_0A, OP_0B: legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] shamt, input logic [5:0] funct);
        return (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
               (32'(rd) << RD_LSB) | (32'(shamt) << SHAMT_LSB) | (32'(funct) << FUNCT_LSB);
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) | (32'(rt) << RT_LSB) |
               (32'(imm) << IMM_LSB);
    endfunction

endpackage

// File: rtl/alu_instr_issuer_if.sv
// Request/issue bundle between an instruction source/ALU side (master)
// and the issuer (slave).
interface alu_instr_issuer_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_itype;
    logic [5:0]  req_op;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [4:0]  req_shamt;
    logic [5:0]  req_funct;
    logic [15:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rtype;
    logic [31:0] out_itype;
    logic        out_is_itype;
    logic        err_illegal;

    modport master (
        output req_valid, req_itype, req_op, req_rs, req_rt, req_rd, req_shamt,
               req_funct, req_imm, out_ready,
        input  req_ready, out_valid, out_rtype, out_itype, out_is_itype, err_illegal
    );

    modport slave (
        input  req_valid, req_itype, req_op, req_rs, req_rt, req_rd, req_shamt,
               req_funct, req_imm, out_ready,
        output req_ready, out_valid, out_rtype, out_itype, out_is_itype, err_illegal
    );
endinterface

// File: rtl/alu_issuer_fifo.sv
// In-order first-word-fall-through buffer: the head entry is visible on
// dout_o as soon as it is written. Caller guarantees no push when full and
// no pop when empty.
module alu_issuer_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 33,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [W-1:0]     din_i,
    input  logic             pop_i,
    output logic [W-1:0]     dout_o,
    output logic [PTR_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Next-state for pointers and occupancy; pointers wrap naturally
    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_i  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset because empty masks them
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy registers, flushed by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/alu_instr_issuer.sv
// ALU instruction issuer: encodes R/I-type words, drops illegal opcodes
// with a one-cycle error pulse, buffers legal words and presents the head
// on the R-type or I-type bus.
// Optional feature macro: ALU_ISSUER_ERRCNT_EN adds a saturating err_count.
module alu_instr_issuer
    import alu_issuer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_instr_issuer_if.slave  bus
`ifdef ALU_ISSUER_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]   err_count
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]        word;
    logic               legal;
    logic               accept;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;
    logic [PTR_W:0]     count;
    logic               full;
    logic               empty;
    logic               r_sel;
    logic               i_sel;
    logic               err_q;

    // Encode the incoming fields and classify the opcode
    always_comb begin
        legal = is_legal_op(bus.req_op);
        word  = bus.req_itype ? enc_i(bus.req_op, bus.req_rs, bus.req_rt, bus.req_imm)
                              : enc_r(bus.req_op, bus.req_rs, bus.req_rt, bus.req_rd,
                                      bus.req_shamt, bus.req_funct);
    end

    assign accept = bus.req_valid && bus.req_ready;
    assign push   = accept && legal;
    assign pop    = bus.out_ready && !empty;

    alu_issuer_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   ({bus.req_itype, word}),
        .pop_i   (pop),
        .dout_o  (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Ready reflects registered occupancy, so a pop frees space only next cycle
    assign bus.req_ready    = !full;
    assign bus.out_valid    = (count != '0);
    assign bus.out_is_itype = !empty && head[ENTRY_W-1];
    assign r_sel            = !empty && !head[ENTRY_W-1];
    assign i_sel            = !empty && head[ENTRY_W-1];

    // Steer the head word onto exactly one bus; the other reads zero
    for (genvar gi = 0; gi < 32; gi++) begin : g_bus_split
        assign bus.out_rtype[gi] = head[gi] & r_sel;
        assign bus.out_itype[gi] = head[gi] & i_sel;
    end

    // One-cycle pulse for each accepted-but-dropped illegal opcode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && !legal;
        end
    end

    assign bus.err_illegal = err_q;

`ifdef ALU_ISSUER_ERRCNT_EN
    localparam logic [CNT_W-1:0] ERR_ONE = CNT_W'(1);

    logic [CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (accept && !legal && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_ONE;
        end
    end

    // Saturating count of dropped illegal opcodes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_alu_instr_issuer.sv
// Scoreboard bench for alu_instr_issuer: stimulus pushes expected words,
// a negedge monitor pops and compares every issued word.
module tb_alu_instr_issuer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_instr_issuer_if bus_if ();

`ifdef ALU_ISSUER_ERRCNT_EN
    logic [7:0] err_count;
    int         err_cnt_exp = 0;
`endif

    alu_instr_issuer #(
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
`ifdef ALU_ISSUER_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: compare every issued word against the scoreboard, and check
    // that idle buses are zero
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_issue: got r=%08h i=%08h expected no word",
                             bus_if.out_rtype, bus_if.out_itype);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    $display("issue: is_itype=%0b rtype=%08h itype=%08h (exp %0b %08h)",
                             bus_if.out_is_itype, bus_if.out_rtype, bus_if.out_itype,
                             e[32], e[31:0]);
                    check("out_rtype", bus_if.out_rtype, e[32] ? 32'h0 : e[31:0]);
                    check("out_itype", bus_if.out_itype, e[32] ? e[31:0] : 32'h0);
                    check("out_is_itype", 32'(bus_if.out_is_itype), 32'(e[32]));
                end
            end else if (bus_if.out_valid === 1'b0) begin
                check("idle_rtype", bus_if.out_rtype, 32'h0);
                check("idle_itype", bus_if.out_itype, 32'h0);
            end
        end
    end

    task automatic drive(input logic it, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [5:0] fn, input logic [15:0] imm);
        bus_if.req_valid = 1'b1;
        bus_if.req_itype = it;
        bus_if.req_op    = op;
        bus_if.req_rs    = rs;
        bus_if.req_rt    = rt;
        bus_if.req_rd    = rd;
        bus_if.req_shamt = sh;
        bus_if.req_funct = fn;
        bus_if.req_imm   = imm;
    endtask

    // One handshake; expected word queued only if it should be issued.
    // Called at posedge+1, returns at posedge+1 after the accepting edge.
    task automatic send(input logic it, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] imm,
                        input logic [31:0] exp_word, input bit expect_issue);
        int guard;
        drive(it, op, rs, rt, rd, sh, fn, imm);
        guard = 0;
        @(negedge clk);
        while (bus_if.req_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL req_ready_timeout: got req_ready=%0b expected 1", bus_if.req_ready);
        end
        if (expect_issue) exp_q.push_back({it, exp_word});
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        $display("send: itype=%0b op=%02h word=%08h issue=%0b", it, op, exp_word, expect_issue);
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check(name, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_itype = 1'b0;
        bus_if.req_op    = '0;
        bus_if.req_rs    = '0;
        bus_if.req_rt    = '0;
        bus_if.req_rd    = '0;
        bus_if.req_shamt = '0;
        bus_if.req_funct = '0;
        bus_if.req_imm   = '0;
        bus_if.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(bus_if.req_ready), 32'h1);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'h0);
        check("rst_out_is_itype", 32'(bus_if.out_is_itype), 32'h0);
        check("rst_err_illegal", 32'(bus_if.err_illegal), 32'h0);
`ifdef ALU_ISSUER_ERRCNT_EN
        check("rst_err_count", 32'(err_count), 32'h0);
`endif
        @(posedge clk);
        #1;

        // R-type, next-cycle latency
        send(1'b0, 6'h01, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hABCD, 32'h04221820, 1'b1);
        @(negedge clk);
        check("r_latency_valid", 32'(bus_if.out_valid), 32'h1);
        check("r_no_err", 32'(bus_if.err_illegal), 32'h0);
        wait_drain("r_drain");

        // I-type with R-only fields set (must be ignored)
        send(1'b1, 6'h0A, 5'd4, 5'd5, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 32'h2885FFFF, 1'b1);
        wait_drain("i_drain");

        // Illegal opcodes: dropped, single-cycle error pulse
        begin
            logic [5:0] bad_ops [4];
            bad_ops = '{6'h07, 6'h08, 6'h0C, 6'h3F};
            for (int k = 0; k < 4; k++) begin
                send(1'b0, bad_ops[k], 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0, 32'h0, 1'b0);
                @(negedge clk);
                check("illegal_err_pulse", 32'(bus_if.err_illegal), 32'h1);
                check("illegal_no_valid", 32'(bus_if.out_valid), 32'h0);
`ifdef ALU_ISSUER_ERRCNT_EN
                err_cnt_exp++;
                check("illegal_err_count", 32'(err_count), 32'(err_cnt_exp));
`endif
                @(negedge clk);
                check("illegal_err_clear", 32'(bus_if.err_illegal), 32'h0);
                @(posedge clk);
                #1;
            end
        end

        // Fill to DEPTH with ALU stalled, then drain
        bus_if.out_ready = 1'b0;
        send(1'b0, 6'h00, 5'd0,  5'd0,  5'd0, 5'd0, 6'h21, 16'h0,    32'h00000021, 1'b1);
        send(1'b0, 6'h02, 5'd3,  5'd4,  5'd5, 5'd6, 6'h2A, 16'h0,    32'h086429AA, 1'b1);
        send(1'b1, 6'h0B, 5'd31, 5'd0,  5'd0, 5'd0, 6'h00, 16'h1234, 32'h2FE01234, 1'b1);
        send(1'b1, 6'h06, 5'd0,  5'd31, 5'd0, 5'd0, 6'h00, 16'h0000, 32'h181F0000, 1'b1);
        @(negedge clk);
        check("full_req_ready", 32'(bus_if.req_ready), 32'h0);
        check("full_out_valid", 32'(bus_if.out_valid), 32'h1);
        check("full_head_stable", bus_if.out_rtype, 32'h00000021);
        @(posedge clk);
        #1 bus_if.out_ready = 1'b1;
        @(negedge clk);
        check("full_pop_cycle_ready", 32'(bus_if.req_ready), 32'h0);
        @(negedge clk);
        check("after_pop_ready", 32'(bus_if.req_ready), 32'h1);
        repeat (2) @(negedge clk);
        #1;
        check("drain_one_per_cycle", 32'(exp_q.size()), 32'h0);
        @(posedge clk);
        #1;

        // Reset with three buffered words
        bus_if.out_ready = 1'b0;
        send(1'b0, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 32'h0C000000, 1'b0);
        send(1'b0, 6'h04, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 32'h10000000, 1'b0);
        send(1'b0, 6'h05, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 32'h14000000, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus_if.out_valid), 32'h0);
        check("midrst_req_ready", 32'(bus_if.req_ready), 32'h1);
        check("midrst_rtype", bus_if.out_rtype, 32'h0);
`ifdef ALU_ISSUER_ERRCNT_EN
        err_cnt_exp = 0;
        check("midrst_err_count", 32'(err_count), 32'h0);
`endif
        @(posedge clk);
        #1 bus_if.out_ready = 1'b1;
        send(1'b0, 6'h05, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 32'h14000000, 1'b1);
        wait_drain("post_rst_drain");

        // Steady back-to-back stream
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 6'h03, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'(i));
            exp_q.push_back({1'b1, 32'h0C220000 + 32'(i)});
            @(negedge clk);
            check("stream_req_ready", 32'(bus_if.req_ready), 32'h1);
            if (i > 0) check("stream_out_valid", 32'(bus_if.out_valid), 32'h1);
            @(posedge clk);
            #1;
            $display("stream: push imm=%0d", i);
        end
        bus_if.req_valid = 1'b0;
        wait_drain("stream_drain");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
